// File: rtl/ifetch_queue.sv
// Instruction fetch front end: issues halfword fetches, buffers returned words in a
// small circular queue and hands them to decode one per cycle, tagged with PC and fault.
module ifetch_queue #(
   parameter int             VA       = 24,
   parameter int             DEPTH    = 4,
   parameter logic [VA-1:0]  RESET_PC = '0
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           pc_load,
   input  logic [VA-1:0]  pc_new,
   input  logic           stall,
   output logic           fetch_req,
   output logic [VA-1:0]  fetch_addr,
   input  logic           fetch_ack,
   input  logic [15:0]    fetch_data,
   input  logic           fetch_err,
   output logic [15:0]    ins,
   output logic [VA-1:0]  ins_pc,
   output logic           ins_fault,
   output logic           idone
);

   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW:0]    DEPTH_C  = (AW+1)'(DEPTH);
   localparam logic [VA-1:0]  PC_STEP  = VA'(2);
   localparam logic [VA-1:0]  PC_ALIGN = ~VA'(1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_REQ     = 2'd1;
   localparam logic [1:0] S_HALT    = 2'd2;
   localparam logic [1:0] S_DISCARD = 2'd3;

   logic [1:0]     state, state_nxt;
   logic [VA-1:0]  fetch_pc, fetch_pc_nxt;
   logic [AW-1:0]  rd_ptr, wr_ptr;
   logic [AW:0]    count, count_nxt;
   logic           empty, push, pop;

   logic [15:0]    data_q  [DEPTH];
   logic [VA-1:0]  pc_q    [DEPTH];
   logic           fault_q [DEPTH];

   // Queue head and handshake
   assign empty      = (count == '0);
   assign idone      = !empty && !stall && !pc_load;
   assign pop        = idone;
   assign push       = (state == S_REQ) && fetch_ack && !pc_load;
   assign fetch_req  = (state == S_REQ);
   assign fetch_addr = fetch_pc;

   assign ins       = empty ? '0   : data_q[rd_ptr];
   assign ins_pc    = empty ? '0   : pc_q[rd_ptr];
   assign ins_fault = empty ? 1'b0 : fault_q[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (push && !pop)
         count_nxt = count + (AW+1)'(1);
      else if (pop && !push)
         count_nxt = count - (AW+1)'(1);
   end

   // A request is only launched when its returning word is guaranteed a slot.
   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      if (pc_load) begin
         fetch_pc_nxt = pc_new & PC_ALIGN;
         case (state)
            S_REQ:     state_nxt = fetch_ack ? S_REQ : S_DISCARD;
            S_DISCARD: state_nxt = fetch_ack ? S_REQ : S_DISCARD;
            default:   state_nxt = S_REQ;
         endcase
      end else begin
         case (state)
            S_IDLE: begin
               if (count_nxt < DEPTH_C)
                  state_nxt = S_REQ;
            end
            S_REQ: begin
               if (fetch_ack) begin
                  fetch_pc_nxt = fetch_pc + PC_STEP;
                  if (fetch_err)
                     state_nxt = S_HALT;
                  else if (count_nxt < DEPTH_C)
                     state_nxt = S_REQ;
                  else
                     state_nxt = S_IDLE;
               end
            end
            S_HALT: state_nxt = S_HALT;
            default: begin
               if (fetch_ack)
                  state_nxt = S_REQ;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         fetch_pc <= RESET_PC & PC_ALIGN;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
         if (pc_load) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (pop)
               rd_ptr <= rd_ptr + AW'(1);
            if (push)
               wr_ptr <= wr_ptr + AW'(1);
            count <= count_nxt;
         end
      end
   end

   // Queue storage carries no reset; emptiness is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push) begin
         data_q[wr_ptr]  <= fetch_data;
         pc_q[wr_ptr]    <= fetch_pc;
         fault_q[wr_ptr] <= fetch_err;
      end
   end

endmodule
